// File: rtl/switch_rate_select_pkg.sv
// Shared definitions for the switch-driven rate selector.
// Holds the default tick periods for each rate index, the 2-bit rate index
// constants and the RUN/PAUSED state encoding used by the top level.
package switch_rate_select_pkg;

    // Default tick periods, in clocks, for a 25 MHz system clock.
    localparam int unsigned DEF_COUNT_10HZ = 1250000;
    localparam int unsigned DEF_COUNT_5HZ  = 2500000;
    localparam int unsigned DEF_COUNT_2HZ  = 6250000;
    localparam int unsigned DEF_COUNT_1HZ  = 12500000;

    // Rate index values as seen on o_Rate_Sel.
    localparam logic [1:0] RATE_10HZ = 2'd0;
    localparam logic [1:0] RATE_5HZ  = 2'd1;
    localparam logic [1:0] RATE_2HZ  = 2'd2;
    localparam logic [1:0] RATE_1HZ  = 2'd3;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_PAUSED = 1'b1
    } run_state_t;

endpackage

// File: rtl/switch_rate_select_if.sv
// Bundle of the user-facing signals of switch_rate_select.
//   i_Switch_1  raw push-button, release advances the rate
//   i_Switch_2  raw push-button, release toggles run/pause
//   o_Tick      single-cycle pulse at the selected rate
//   o_Rate_Sel  current rate index (0=10Hz,1=5Hz,2=2Hz,3=1Hz)
//   o_Running   high in RUN, low in PAUSED
//   dbg_state   raw FSM state, for observation only
// There is no valid/ready handshake: the switches are level inputs sampled
// every clock and the outputs are registered levels/pulses.
// master: the environment (drives switches); slave: the design.
interface switch_rate_select_if;
    import switch_rate_select_pkg::*;

    logic       i_Switch_1;
    logic       i_Switch_2;
    logic       o_Tick;
    logic [1:0] o_Rate_Sel;
    logic       o_Running;
    run_state_t dbg_state;

    modport master (
        output i_Switch_1, i_Switch_2,
        input  o_Tick, o_Rate_Sel, o_Running, dbg_state
    );

    modport slave (
        input  i_Switch_1, i_Switch_2,
        output o_Tick, o_Rate_Sel, o_Running, dbg_state
    );
endinterface

// File: rtl/switch_rate_select_debounce_release.sv
// debounce_release: synchronizes one raw push-button, debounces it and
// emits a single-cycle pulse when the debounced level falls (button release).
//   i_Clk      system clock
//   i_Rst_L    asynchronous active-low reset
//   i_Switch   raw asynchronous switch input
//   o_Release  one-cycle pulse, registered, on a debounced 1->0 transition
module debounce_release #(
    parameter int unsigned g_DEBOUNCE_LIMIT = 250000
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_Switch,
    output logic o_Release
);

    localparam int unsigned CNT_W = $clog2(g_DEBOUNCE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(g_DEBOUNCE_LIMIT - 1);

    logic             sync_meta;
    logic             sync_out;
    logic             level;
    logic [CNT_W-1:0] count;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            sync_meta <= 1'b0;
            sync_out  <= 1'b0;
            level     <= 1'b0;
            count     <= '0;
            o_Release <= 1'b0;
        end else begin
            sync_meta <= i_Switch;
            sync_out  <= sync_meta;
            o_Release <= 1'b0;
            if (sync_out == level) begin
                count <= '0;
            end else if (count == CNT_LAST) begin
                // This is the LIMIT-th consecutive differing cycle: accept the
                // new level. A pulse only when the old level was high (release).
                level     <= sync_out;
                count     <= '0;
                o_Release <= level;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/switch_rate_select.sv
// switch_rate_select: two debounced push-buttons control a tick generator.
// Releasing switch 1 cycles the tick rate through four periods; releasing
// switch 2 toggles between RUN (ticking) and PAUSED (prescaler frozen).
//   i_Clk    system clock (only clock)
//   i_Rst_L  asynchronous active-low reset
//   bus      switch_rate_select_if.slave: switches in, tick/rate/running out
module switch_rate_select
    import switch_rate_select_pkg::*;
#(
    parameter int unsigned g_DEBOUNCE_LIMIT = 250000,
    parameter int unsigned g_COUNT_10HZ     = DEF_COUNT_10HZ,
    parameter int unsigned g_COUNT_5HZ      = DEF_COUNT_5HZ,
    parameter int unsigned g_COUNT_2HZ      = DEF_COUNT_2HZ,
    parameter int unsigned g_COUNT_1HZ      = DEF_COUNT_1HZ
) (
    input logic                  i_Clk,
    input logic                  i_Rst_L,
    switch_rate_select_if.slave  bus
);

    logic        rel_1;
    logic        rel_2;
    logic [1:0]  rate;
    logic [31:0] prescaler;
    logic [31:0] limit_m1;
    logic        tick;
    run_state_t  state;
    run_state_t  state_next;

    debounce_release #(.g_DEBOUNCE_LIMIT(g_DEBOUNCE_LIMIT)) u_sw1 (
        .i_Clk     (i_Clk),
        .i_Rst_L   (i_Rst_L),
        .i_Switch  (bus.i_Switch_1),
        .o_Release (rel_1)
    );

    debounce_release #(.g_DEBOUNCE_LIMIT(g_DEBOUNCE_LIMIT)) u_sw2 (
        .i_Clk     (i_Clk),
        .i_Rst_L   (i_Rst_L),
        .i_Switch  (bus.i_Switch_2),
        .o_Release (rel_2)
    );

    // Terminal count for the currently selected rate.
    always_comb begin
        limit_m1 = 32'(g_COUNT_10HZ) - 32'd1;
        case (rate)
            RATE_5HZ: limit_m1 = 32'(g_COUNT_5HZ) - 32'd1;
            RATE_2HZ: limit_m1 = 32'(g_COUNT_2HZ) - 32'd1;
            RATE_1HZ: limit_m1 = 32'(g_COUNT_1HZ) - 32'd1;
            default:  limit_m1 = 32'(g_COUNT_10HZ) - 32'd1;
        endcase
    end

    // FSM state register.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state: each switch-2 release toggles RUN/PAUSED.
    always_comb begin
        state_next = state;
        if (rel_2) begin
            state_next = (state == ST_RUN) ? ST_PAUSED : ST_RUN;
        end
    end

    // Rate register, prescaler and tick. The prescaler follows the state the
    // FSM is entering, so a pause freezes the value present at the release
    // event and a resume counts in the same cycle as the release event.
    // A rate change clears the prescaler and wins over a terminal count.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            rate      <= RATE_10HZ;
            prescaler <= '0;
            tick      <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (rel_1) begin
                rate      <= rate + 2'd1;
                prescaler <= '0;
            end else if (state_next == ST_RUN) begin
                if (prescaler == limit_m1) begin
                    prescaler <= '0;
                    tick      <= 1'b1;
                end else begin
                    prescaler <= prescaler + 32'd1;
                end
            end
        end
    end

    assign bus.o_Tick     = tick;
    assign bus.o_Rate_Sel = rate;
    assign bus.o_Running  = (state == ST_RUN);
    assign bus.dbg_state  = state;

endmodule

// File: tb/tb_switch_rate_select.sv
// Directed bench for switch_rate_select with a small debounce limit and
// short tick periods (10/20/50/100 clocks).
module tb_switch_rate_select;
    import switch_rate_select_pkg::*;

    localparam int DEB = 4;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    switch_rate_select_if bus();

    switch_rate_select #(
        .g_DEBOUNCE_LIMIT (DEB),
        .g_COUNT_10HZ     (10),
        .g_COUNT_5HZ      (20),
        .g_COUNT_2HZ      (50),
        .g_COUNT_1HZ      (100)
    ) dut (
        .i_Clk   (clk),
        .i_Rst_L (rst_n),
        .bus     (bus)
    );

    int total = 0;
    int bad   = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int period(input int r);
        case (r)
            0:       return 10;
            1:       return 20;
            2:       return 50;
            default: return 100;
        endcase
    endfunction

    // ---------------- behavioural model ----------------
    // Switch path: raw input seen two clocks late; the debounced level flips
    // once the delayed input has disagreed with it for DEB sampled clocks; a
    // high-to-low flip is a release visible during the following cycle and
    // acted on at the next edge.
    int m_rate    = 0;
    int m_count   = 0;
    bit m_running = 1'b1;
    bit m_tick    = 1'b0;
    bit m_sync1[2];
    bit m_sync2[2];
    bit m_level[2];
    bit m_ev[2];
    int m_run[2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rate = 0; m_count = 0; m_running = 1'b1; m_tick = 1'b0;
            for (int i = 0; i < 2; i++) begin
                m_sync1[i] = 1'b0; m_sync2[i] = 1'b0; m_level[i] = 1'b0;
                m_ev[i] = 1'b0; m_run[i] = 0;
            end
        end else begin
            bit raw[2];
            bit next_run;
            raw[0] = bus.i_Switch_1;
            raw[1] = bus.i_Switch_2;
            next_run = m_running ^ m_ev[1];
            m_tick = 1'b0;
            if (m_ev[0]) begin
                m_rate  = (m_rate + 1) % 4;
                m_count = 0;
            end else if (next_run) begin
                m_count = m_count + 1;
                if (m_count == period(m_rate)) begin
                    m_count = 0;
                    m_tick  = 1'b1;
                end
            end
            m_running = next_run;
            for (int i = 0; i < 2; i++) begin
                m_ev[i] = 1'b0;
                if (m_sync2[i] != m_level[i]) begin
                    m_run[i] = m_run[i] + 1;
                    if (m_run[i] == DEB) begin
                        m_ev[i]    = m_level[i];
                        m_level[i] = m_sync2[i];
                        m_run[i]   = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
                m_sync2[i] = m_sync1[i];
                m_sync1[i] = raw[i];
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always begin
        @(negedge clk);
        #2;
        if (cmp_en) begin
            check("cyc_tick",    int'(bus.o_Tick),     int'(m_tick));
            check("cyc_rate",    int'(bus.o_Rate_Sel), m_rate);
            check("cyc_running", int'(bus.o_Running),  int'(m_running));
            check("cyc_state",   int'(bus.dbg_state == ST_RUN), int'(m_running));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic press(input bit s1, input bit s2);
        @(negedge clk);
        if (s1) bus.i_Switch_1 = 1'b1;
        if (s2) bus.i_Switch_2 = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    // Drives the release in the current timestep; caller sits at a negedge.
    task automatic release_now(input bit s1, input bit s2);
        if (s1) bus.i_Switch_1 = 1'b0;
        if (s2) bus.i_Switch_2 = 1'b0;
    endtask

    task automatic press_release(input bit s1, input bit s2);
        press(s1, s2);
        release_now(s1, s2);
        repeat (8) @(negedge clk);
    endtask

    // Returns the number of samples until o_Tick is seen high.
    task automatic wait_tick(output int n);
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!bus.o_Tick && n < 400);
        if (!bus.o_Tick) check("tick_timeout", int'(bus.o_Tick), 1);
    endtask

    task automatic wait_model_count(input int target);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (m_count != target && n < 500);
        if (m_count != target) check("count_wait", m_count, target);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        int ticks;
        int prev_cnt;
        bus.i_Switch_1 = 1'b0;
        bus.i_Switch_2 = 1'b0;
        cmp_en = 1'b1;

        // Reset state.
        repeat (3) @(negedge clk);
        #1;
        check("rst_tick",    int'(bus.o_Tick), 0);
        check("rst_rate",    int'(bus.o_Rate_Sel), 0);
        check("rst_running", int'(bus.o_Running), 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle: tick every 10 clocks, first one 10 clocks after release.
        wait_tick(n); check("first_tick_10", n, 10);
        wait_tick(n); check("tick_period_10a", n, 10);
        wait_tick(n); check("tick_period_10b", n, 10);
        check("idle_rate", int'(bus.o_Rate_Sel), 0);

        // Switch 1 high 8 / low 8: rate 1, tick 20 clocks after the clear.
        press(1'b1, 1'b0);
        release_now(1'b1, 1'b0);
        n = 0;
        do begin @(negedge clk); #1; n++; end while (bus.o_Rate_Sel == 2'd0 && n < 30);
        check("rate_to_1", int'(bus.o_Rate_Sel), 1);
        wait_tick(n); check("tick_after_clear_20", n, 20);
        wait_tick(n); check("tick_period_20", n, 20);

        // Glitch of 3 clocks is ignored.
        @(negedge clk);
        bus.i_Switch_1 = 1'b1;
        repeat (3) @(negedge clk);
        bus.i_Switch_1 = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        check("glitch_rate_hold", int'(bus.o_Rate_Sel), 1);

        // Further releases: 2, 3, then wrap to 0.
        press_release(1'b1, 1'b0); #1; check("rate_to_2", int'(bus.o_Rate_Sel), 2);
        press_release(1'b1, 1'b0); #1; check("rate_to_3", int'(bus.o_Rate_Sel), 3);
        press_release(1'b1, 1'b0); #1; check("rate_wrap_0", int'(bus.o_Rate_Sel), 0);

        // Pause with the prescaler at 6: release driven when count is 0 is
        // acted on six clocks later.
        press(1'b0, 1'b1);
        wait_model_count(0);
        release_now(1'b0, 1'b1);
        n = 0;
        do begin @(negedge clk); #1; n++; end while (bus.o_Running && n < 30);
        check("paused", int'(bus.o_Running), 0);
        check("model_held_6", m_count, 6);
        ticks = 0;
        repeat (200) begin
            @(negedge clk); #1;
            if (bus.o_Tick) ticks++;
        end
        check("no_ticks_paused", ticks, 0);

        // Resume: 7, 8, 9 then tick -> tick 3 samples after Running rises
        // (4 cycles after the release event).
        press(1'b0, 1'b1);
        release_now(1'b0, 1'b1);
        n = 0;
        do begin @(negedge clk); #1; n++; end while (!bus.o_Running && n < 30);
        check("resumed", int'(bus.o_Running), 1);
        wait_tick(n); check("resume_tick_3", n, 3);

        // Simultaneous releases with the prescaler at 9.
        press(1'b1, 1'b1);
        wait_model_count(3);
        release_now(1'b1, 1'b1);
        n = 0;
        prev_cnt = m_count;
        do begin
            prev_cnt = m_count;
            @(negedge clk); #1; n++;
        end while (bus.o_Rate_Sel == 2'd0 && n < 30);
        check("both_prev_count_9", prev_cnt, 9);
        check("both_rate", int'(bus.o_Rate_Sel), 1);
        check("both_running", int'(bus.o_Running), 0);
        check("both_no_tick", int'(bus.o_Tick), 0);

        // Back to RUN at rate 2.
        press_release(1'b0, 1'b1); #1; check("run_again", int'(bus.o_Running), 1);
        press_release(1'b1, 1'b0); #1; check("rate_2_again", int'(bus.o_Rate_Sel), 2);

        // Reset mid-count at rate 2.
        repeat (17) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_tick",    int'(bus.o_Tick), 0);
        check("midrst_rate",    int'(bus.o_Rate_Sel), 0);
        check("midrst_running", int'(bus.o_Running), 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_tick(n); check("post_rst_tick_10", n, 10);
        wait_tick(n); check("post_rst_period_10", n, 10);

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete, time=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/switch_rate_select.md
SWITCH_RATE_SELECT -- requirements
Module: switch_rate_select

Interface
REQ-001 Parameter g_DEBOUNCE_LIMIT, default 250000: consecutive stable cycles needed to accept a switch change (10 ms at 25 MHz).
REQ-002 Parameters g_COUNT_10HZ=1250000, g_COUNT_5HZ=2500000, g_COUNT_2HZ=6250000, g_COUNT_1HZ=12500000: tick period in clocks per rate index 0..3.
REQ-003 i_Clk  input  1  system clock; the only clock; all state SHALL be clocked on its rising edge.
REQ-004 i_Rst_L  input  1  asynchronous, active-low reset.
REQ-005 i_Switch_1  input  1  raw, asynchronous push-button; release advances the rate.
REQ-006 i_Switch_2  input  1  raw, asynchronous push-button; release toggles run/pause.
REQ-007 o_Tick  output  1  single-cycle pulse at the selected rate; the downstream LED toggler flips its LED once per pulse.
REQ-008 o_Rate_Sel  output  2  current rate index: 0=10Hz, 1=5Hz, 2=2Hz, 3=1Hz.
REQ-009 o_Running  output  1  high in RUN, low in PAUSED.

Function
REQ-010 Each switch SHALL pass through a 2-flop synchronizer before any other logic.
REQ-011 Debounce: the debounced level SHALL take the synchronized value only after that value has differed from the current debounced level for g_DEBOUNCE_LIMIT consecutive cycles; any cycle where they are equal clears the counter to 0.
REQ-012 Debounce counter width SHALL be $clog2(g_DEBOUNCE_LIMIT+1) and SHALL never wrap.
REQ-013 A release event SHALL be a debounced 1->0 transition, producing exactly one internal single-cycle event; a press (0->1) SHALL produce no event.
REQ-014 Switch-1 release SHALL advance o_Rate_Sel by 1, wrapping 3->0; update visible the cycle after the event.
REQ-015 FSM states RUN and PAUSED; Switch-2 release SHALL move RUN->PAUSED or PAUSED->RUN.
REQ-016 In RUN the prescaler SHALL count 0..limit-1 for the selected rate; o_Tick SHALL be asserted (registered) for the one cycle following count==limit-1, and the count SHALL return to 0; tick period = limit clocks exactly.
REQ-017 In PAUSED the prescaler SHALL hold its value and o_Tick SHALL be 0; on return to RUN counting SHALL resume from the held value.
REQ-018 A rate change SHALL clear the prescaler to 0 and suppress any tick due in the same cycle (rate change wins over terminal count).
REQ-019 Rate change while PAUSED SHALL update o_Rate_Sel and clear the prescaler; state stays PAUSED.
REQ-020 Simultaneous Switch-1 and Switch-2 release events SHALL both take effect in the same cycle.
REQ-021 Prescaler SHALL be 32 bits wide; comparison SHALL use limit-1 of the currently selected rate.

Reset
REQ-022 On i_Rst_L low, asynchronously: o_Tick=0, o_Rate_Sel=0, o_Running=1 (RUN), prescaler=0, synchronizers=0, debounced levels=0, debounce counters=0.
REQ-023 Reset asserted mid-count or mid-debounce SHALL discard all progress; no tick and no event SHALL be generated by reset deassertion itself.

Structure
REQ-024 Shared package SHALL hold the four rate-limit defaults, the 2-bit rate index constants and the RUN/PAUSED state encoding.
REQ-025 Synchronizer, debounce and release detection SHALL live in one sub-module, debounce_release, instantiated twice.

Verification (g_DEBOUNCE_LIMIT=4; counts 10/20/50/100)
REQ-026 Reset release, switches idle -> o_Tick every 10 cycles, o_Rate_Sel=0, o_Running=1.
REQ-027 Switch-1 high 8 cycles then low 8 cycles -> o_Rate_Sel=1, next tick exactly 20 cycles after the prescaler clear, then every 20 cycles.
REQ-028 Switch-1 glitch high 3 cycles -> no debounced change, o_Rate_Sel unchanged; four valid releases -> o_Rate_Sel wraps 3->0.
REQ-029 Switch-2 release at prescaler=6 -> o_Running=0, no ticks for 200 cycles; second release -> first tick 4 cycles after resume.
REQ-030 Switch-1 and Switch-2 release events in the same cycle with prescaler=9 -> no tick, o_Rate_Sel incremented, o_Running toggled.
REQ-031 i_Rst_L pulsed low mid-count at rate 2 -> all outputs at reset values immediately; ticks every 10 cycles after release.
